// File: rtl/encoder_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Phase encoding keeps {A,B} directly in the enum value so outputs are plain flop bits.
package encoder_pkg;

  localparam int DEFAULT_COUNTS_PER_REV = 16384;

  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form (feedback from bits 0,2,3,5)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } quad_phase_t;

  function automatic quad_phase_t next_phase_fwd(input quad_phase_t ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      PH_10:   return PH_00;
      default: return PH_00;
    endcase
  endfunction

  function automatic quad_phase_t next_phase_rev(input quad_phase_t ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      PH_01:   return PH_00;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/encoder_step_timer.sv
// Quarter-step divider: emits a one-cycle step pulse every period cycles; period 0 halts.
// Optional macro ENCODER_EMU_JITTER_EN stretches each quarter-step by lfsr[1:0] cycles.
module encoder_step_timer
  import encoder_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);

  // Two extra bits leave headroom for the jitter extension of up to +3 cycles
  localparam int CW = PERIOD_W + 2;

  logic [CW-1:0] div_q;
  logic [CW-1:0] terminal;
  logic          running;

  assign running = (period != '0);

`ifdef ENCODER_EMU_JITTER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);

  always_comb begin
    terminal = CW'(period) - CW'(1) + CW'(lfsr_q[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  always_comb begin
    terminal = CW'(period) - CW'(1);
  end
`endif

  assign step = running && (div_q == terminal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (!running || step) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + CW'(1);
    end
  end

endmodule

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: config handshake, A/B phase FSM, position/revolution/index.
// Build option ENCODER_EMU_JITTER_EN adds LFSR jitter to the quarter-step length.
module encoder_emulator
  import encoder_pkg::*;
#(
  parameter int COUNTS_PER_REV = DEFAULT_COUNTS_PER_REV,
  parameter int PERIOD_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [PERIOD_W-1:0]               cfg_period,
  input  logic                              cfg_dir,
  output logic                              a_signal,
  output logic                              b_signal,
  output logic                              index_signal,
  output logic [$clog2(COUNTS_PER_REV)-1:0] position,
  output logic [15:0]                       rev_count
);

  localparam int               POS_W   = $clog2(COUNTS_PER_REV);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(COUNTS_PER_REV - 1);

  logic [PERIOD_W-1:0] period_q;
  logic                dir_q;
  logic                pend_valid;
  logic [PERIOD_W-1:0] pend_period;
  logic                pend_dir;

  logic                step;
  logic                accept;
  logic                apply;

  quad_phase_t         phase_q;
  quad_phase_t         phase_d;
  logic [1:0]          phase_bits_q;
  logic [1:0]          phase_bits_d;
  logic                a_rise;

  logic [POS_W-1:0]    position_q;
  logic [POS_W-1:0]    position_next;
  logic [15:0]         rev_q;
  logic                index_q;

  encoder_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .period (period_q),
    .step   (step)
  );

  // Pending config lands at a quarter-step boundary, or immediately when halted
  assign cfg_ready = ~pend_valid;
  assign accept    = cfg_valid && !pend_valid;
  assign apply     = pend_valid && ((period_q == '0) || step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_period <= '0;
      pend_dir    <= 1'b0;
      period_q    <= '0;
      dir_q       <= 1'b0;
    end else begin
      if (apply) begin
        period_q <= pend_period;
        dir_q    <= pend_dir;
      end
      if (accept) begin
        pend_valid  <= 1'b1;
        pend_period <= cfg_period;
        pend_dir    <= cfg_dir;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_00;
    end else begin
      phase_q <= phase_d;
    end
  end

  // The step at which a new direction is applied still moves in the old direction
  always_comb begin
    phase_d = phase_q;
    if (step) begin
      phase_d = dir_q ? next_phase_rev(phase_q) : next_phase_fwd(phase_q);
    end
  end

  assign phase_bits_q  = phase_q;
  assign phase_bits_d  = phase_d;
  assign a_rise        = step && phase_bits_d[1] && !phase_bits_q[1];
  assign position_next = dir_q ? (position_q - POS_W'(1)) : (position_q + POS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position_q <= '0;
      rev_q      <= '0;
      index_q    <= 1'b0;
    end else if (a_rise) begin
      position_q <= position_next;
      index_q    <= (position_next == '0);
      if (!dir_q && (position_q == POS_MAX)) begin
        rev_q <= rev_q + 16'd1;
      end else if (dir_q && (position_q == '0)) begin
        rev_q <= rev_q - 16'd1;
      end
    end else if (step) begin
      index_q <= 1'b0;
    end
  end

  assign a_signal     = phase_bits_q[1];
  assign b_signal     = phase_bits_q[0];
  assign index_signal = index_q;
  assign position     = position_q;
  assign rev_count    = rev_q;

endmodule
